// File: rtl/pll_cen_pkg.sv
// Shared FSM state type and default sizing for the PLL clock-enable generator.
package pll_cen_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        RUN       = 2'd2
    } pll_state_e;

    localparam int ACC_W_DEF       = 32;
    localparam int LOCK_CYCLES_DEF = 1024;

endpackage

// File: rtl/pll_cen_chan.sv
// One clock-enable channel: phase accumulator, active step, pending step update,
// registered carry-out enable and divided-clock toggle.
module pll_cen_chan
    import pll_cen_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             run,
    input  logic             sync,
    input  logic             wr_en,
    input  logic [ACC_W-1:0] wr_step,
    output logic             pending,
    output logic             cen,
    output logic             clk_div
);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] step;
    logic [ACC_W-1:0] pend_step;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             apply;

    // A zero step can never carry, so a disabled channel never pulses cen.
    always_comb begin
        sum   = {1'b0, acc} + {1'b0, step};
        carry = sum[ACC_W];
        apply = pending && (carry || (step == '0) || !run);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            acc       <= '0;
            step      <= '0;
            pend_step <= '0;
            pending   <= 1'b0;
            cen       <= 1'b0;
            clk_div   <= 1'b0;
        end else begin
            if (!run || sync) begin
                acc     <= '0;
                cen     <= 1'b0;
                clk_div <= 1'b0;
            end else begin
                acc <= sum[ACC_W-1:0];
                cen <= carry;
                if (carry) begin
                    clk_div <= ~clk_div;
                end
            end
            // ready is low while pending, so a write and an apply never coincide
            if (apply) begin
                step    <= pend_step;
                pending <= 1'b0;
            end else if (wr_en) begin
                pend_step <= wr_step;
                pending   <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pll_cen_gen.sv
// Clock-enable generator in the PLL output domain: waits for a settled lock,
// then runs NUM_CLOCKS fractional phase-accumulator enable channels.
//
// state     | meaning
// ----------+-----------------------------------------------------
// WAIT_LOCK | PLL not locked; channels held idle
// SETTLE    | lock seen, counting LOCK_CYCLES before enabling
// RUN       | channels accumulate and emit cen pulses
module pll_cen_gen
    import pll_cen_pkg::*;
#(
    parameter int  NUM_CLOCKS  = 2,
    parameter int  ACC_W       = ACC_W_DEF,
    parameter int  LOCK_CYCLES = LOCK_CYCLES_DEF,
    localparam int CH_W        = (NUM_CLOCKS > 1) ? $clog2(NUM_CLOCKS) : 1
) (
    input  logic                  refclk,
    input  logic                  rst,
    input  logic                  locked,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [ACC_W-1:0]      cfg_step,
    input  logic                  sync,
    output logic [NUM_CLOCKS-1:0] cen,
    output logic [NUM_CLOCKS-1:0] clk_div,
    output logic                  running
);

    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(LOCK_CYCLES - 1);

    pll_state_e             state;
    pll_state_e             state_next;
    logic [CNT_W-1:0]       settle_cnt;
    logic                   lock_meta;
    logic                   locked_s;
    logic                   run_en;
    logic                   sync_en;
    logic [NUM_CLOCKS-1:0]  pend;
    logic [NUM_CLOCKS-1:0]  wr_en;

    always_ff @(posedge refclk) begin
        if (rst) begin
            lock_meta  <= 1'b0;
            locked_s   <= 1'b0;
            state      <= WAIT_LOCK;
            settle_cnt <= '0;
        end else begin
            lock_meta <= locked;
            locked_s  <= lock_meta;
            state     <= state_next;
            if (state == SETTLE) begin
                settle_cnt <= settle_cnt + 1'b1;
            end else begin
                settle_cnt <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_LOCK: if (locked_s) state_next = SETTLE;
            SETTLE: begin
                if (!locked_s) begin
                    state_next = WAIT_LOCK;
                end else if (settle_cnt == SETTLE_LAST) begin
                    state_next = RUN;
                end
            end
            RUN:       if (!locked_s) state_next = WAIT_LOCK;
            default:   state_next = WAIT_LOCK;
        endcase
    end

    // Channels only advance when RUN is held across the edge, so cen and
    // clk_div are already cleared on the edge that leaves RUN.
    assign running = (state == RUN);
    assign run_en  = running && locked_s;
    assign sync_en = sync && run_en;

    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CLOCKS; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = !pend[i];
            end
        end
    end

    for (genvar i = 0; i < NUM_CLOCKS; i++) begin : g_chan
        assign wr_en[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

        pll_cen_chan #(
            .ACC_W (ACC_W)
        ) u_chan (
            .refclk  (refclk),
            .rst     (rst),
            .run     (run_en),
            .sync    (sync_en),
            .wr_en   (wr_en[i]),
            .wr_step (cfg_step),
            .pending (pend[i]),
            .cen     (cen[i]),
            .clk_div (clk_div[i])
        );
    end

endmodule

// File: tb/tb_pll_cen_gen.sv
// Directed bench for pll_cen_gen with a cycle-level behavioural model and
// hand-computed literal expectations for lock timing and enable patterns.
module tb_pll_cen_gen;

    localparam int NCH = 2;
    localparam int AW  = 8;
    localparam int LC  = 4;
    localparam int MOD = 1 << AW;

    logic          refclk = 1'b0;
    logic          rst = 1'b1;
    logic          locked = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_ready;
    logic [0:0]    cfg_ch = 1'b0;
    logic [AW-1:0] cfg_step = '0;
    logic          sync = 1'b0;
    logic [NCH-1:0] cen;
    logic [NCH-1:0] clk_div;
    logic          running;

    int checks = 0;
    int errors = 0;

    always #5 refclk = ~refclk;

    pll_cen_gen #(
        .NUM_CLOCKS  (NCH),
        .ACC_W       (AW),
        .LOCK_CYCLES (LC)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .locked    (locked),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_step  (cfg_step),
        .sync      (sync),
        .cen       (cen),
        .clk_div   (clk_div),
        .running   (running)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0d expected=%0d", name, $time, act, exp);
        end
    endtask

    // Model: locked_s is locked seen two edges late; RUN holds once locked_s
    // has been high on LC+1 consecutive edges.
    int  m_acc[NCH];
    int  m_step[NCH];
    int  m_pstep[NCH];
    bit  m_pend[NCH];
    bit  m_cen[NCH];
    bit  m_div[NCH];
    bit  m_lk1, m_lk2, m_run;
    int  m_streak;
    bit  chk_en = 1'b0;

    always @(posedge refclk) begin
        bit lks;
        bit ch_run;
        bit accept;
        bit carry;
        int tot;
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_acc[i] = 0; m_step[i] = 0; m_pstep[i] = 0;
                m_pend[i] = 0; m_cen[i] = 0; m_div[i] = 0;
            end
            m_lk1 = 0; m_lk2 = 0; m_run = 0; m_streak = 0;
        end else begin
            lks    = m_lk2;
            ch_run = m_run && lks;
            accept = cfg_valid && (int'(cfg_ch) < NCH) && !m_pend[cfg_ch];
            for (int i = 0; i < NCH; i++) begin
                tot   = m_acc[i] + m_step[i];
                carry = (tot >= MOD);
                if (!ch_run || sync) begin
                    m_acc[i] = 0; m_cen[i] = 0; m_div[i] = 0;
                end else begin
                    m_acc[i] = tot % MOD;
                    m_cen[i] = carry;
                    if (carry) m_div[i] = !m_div[i];
                end
                if (m_pend[i] && (carry || m_step[i] == 0 || !ch_run)) begin
                    m_step[i] = m_pstep[i];
                    m_pend[i] = 0;
                end else if (accept && int'(cfg_ch) == i) begin
                    m_pstep[i] = int'(cfg_step);
                    m_pend[i]  = 1;
                end
            end
            m_lk2    = m_lk1;
            m_lk1    = locked;
            m_streak = lks ? ((m_streak < 1000) ? m_streak + 1 : m_streak) : 0;
            m_run    = (m_streak >= LC + 1);
        end
    end

    always @(negedge refclk) begin
        bit m_ready;
        if (chk_en) begin
            m_ready = (int'(cfg_ch) >= NCH) ? 1'b1 : !m_pend[cfg_ch];
            chk("model_running", int'(running), int'(m_run));
            chk("model_ready", int'(cfg_ready), int'(m_ready));
            for (int i = 0; i < NCH; i++) begin
                chk($sformatf("model_cen%0d", i), int'(cen[i]), int'(m_cen[i]));
                chk($sformatf("model_div%0d", i), int'(clk_div[i]), int'(m_div[i]));
            end
        end
    end

    task automatic tick();
        @(posedge refclk);
        #2;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        do begin
            @(negedge refclk);
            n++;
        end while (!cfg_ready && n < 40);
        if (!cfg_ready) chk(name, 0, 1);
    endtask

    task automatic wait_cen0(input string name);
        int n;
        n = 0;
        while (!cen[0] && n < 40) begin
            @(negedge refclk);
            n++;
        end
        if (!cen[0]) chk(name, 0, 1);
    endtask

    task automatic count_to_running(output int n);
        n = 0;
        do begin
            @(negedge refclk);
            n++;
        end while (!running && n < 20);
    endtask

    task automatic watch(input int ch, input int ncyc, output int np, output int gap,
                         output int dgap, output int n_other);
        int  p1, p2, r1, r2;
        logic pd;
        np = 0; n_other = 0; p1 = -1; p2 = -1; r1 = -1; r2 = -1;
        pd = clk_div[ch];
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge refclk);
            if (cen[ch]) begin
                np++;
                if (p1 < 0) p1 = i; else if (p2 < 0) p2 = i;
            end
            if (cen[1 - ch]) n_other++;
            if (clk_div[ch] && !pd) begin
                if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
            end
            pd = clk_div[ch];
        end
        gap  = (p2 > 0) ? p2 - p1 : -1;
        dgap = (r2 > 0) ? r2 - r1 : -1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, cnt, np, gap, dgap, nother, pat, f0, f1;

        rst = 1'b1;
        repeat (3) tick();
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge refclk);
        chk("rst_running", int'(running), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_cen", int'(cen), 0);
        chk("rst_clk_div", int'(clk_div), 0);

        locked = 1'b1;
        count_to_running(n);
        chk("lock_to_running_edges", n, 7);

        // lock lost during SETTLE never reaches RUN
        rst = 1'b1; locked = 1'b0;
        tick(); tick();
        rst = 1'b0; locked = 1'b1;
        repeat (4) tick();
        locked = 1'b0;
        cnt = 0;
        repeat (12) begin
            @(negedge refclk);
            if (running) cnt++;
        end
        chk("settle_abort_running", cnt, 0);

        locked = 1'b1;
        count_to_running(n);
        chk("relock_after_abort_edges", n, 7);

        // ch0 step 64: first write applies next edge since step is 0
        tick();
        cfg_ch = 1'b0; cfg_step = 8'd64; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        @(negedge refclk);
        chk("pending_ready_low", int'(cfg_ready), 0);
        watch(0, 20, np, gap, dgap, nother);
        chk("step64_pulses", np, 4);
        chk("step64_cen_period", gap, 4);
        chk("step64_div_period", dgap, 8);
        chk("ch1_disabled_pulses", nother, 0);

        // ch0 step 96 from acc 0: 96,192,32c,128,224,64c,160,0c
        cfg_step = 8'd96; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        wait_ready("step96_apply_timeout");
        pat = 0;
        repeat (8) begin
            @(negedge refclk);
            pat = (pat << 1) | int'(cen[0]);
        end
        chk("step96_pattern", pat, 8'b0010_0101);

        // back to 64, then a mid-period write of 128 with a second write stalled
        tick();
        cfg_step = 8'd64; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        wait_ready("step64_apply_timeout");
        wait_cen0("step64_cen_timeout");
        tick();
        cfg_step = 8'd128; cfg_valid = 1'b1;
        tick();
        cfg_step = 8'd32;
        cnt = 0;
        do begin
            @(negedge refclk);
            if (!cfg_ready) cnt++;
        end while (!cfg_ready && cnt < 20);
        cfg_valid = 1'b0;
        chk("midperiod_stall_cycles", cnt, 2);
        chk("ready_returns_with_cen", int'(cen[0]), 1);
        watch(0, 8, np, gap, dgap, nother);
        chk("step128_pulses", np, 4);
        chk("step128_cen_period", gap, 2);
        chk("step128_div_period", dgap, 4);

        // lock drop in RUN, then relock from a cleared accumulator
        locked = 1'b0;
        n = 0;
        do begin
            @(negedge refclk);
            n++;
        end while (running && n < 20);
        chk("unlock_to_idle_edges", n, 3);
        chk("unlock_cen", int'(cen), 0);
        chk("unlock_clk_div", int'(clk_div), 0);
        repeat (3) @(negedge refclk);
        locked = 1'b1;
        count_to_running(n);
        chk("relock_edges", n, 7);
        n = 0;
        while (!cen[0] && n < 20) begin
            @(negedge refclk);
            n++;
        end
        chk("relock_first_cen128", n, 2);

        // steps 64/32 then sync on an edge where ch0 would carry
        tick();
        cfg_ch = 1'b0; cfg_step = 8'd64; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        wait_ready("sync_ch0_apply_timeout");
        tick();
        cfg_ch = 1'b1; cfg_step = 8'd32; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        wait_ready("sync_ch1_apply_timeout");
        wait_cen0("sync_align_timeout");
        repeat (3) @(posedge refclk);
        #2;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        @(negedge refclk);
        chk("sync_edge_cen", int'(cen), 0);
        chk("sync_edge_clk_div", int'(clk_div), 0);
        f0 = -1; f1 = -1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge refclk);
            if (cen[0] && f0 < 0) f0 = i;
            if (cen[1] && f1 < 0) f1 = i;
        end
        chk("sync_first_cen0", f0, 4);
        chk("sync_first_cen1", f1, 8);

        // reset mid-RUN and mid-handshake
        tick();
        cfg_ch = 1'b0; cfg_step = 8'd10; cfg_valid = 1'b1; rst = 1'b1;
        tick();
        @(negedge refclk);
        chk("midrun_rst_running", int'(running), 0);
        chk("midrun_rst_ready", int'(cfg_ready), 1);
        chk("midrun_rst_cen", int'(cen), 0);
        rst = 1'b0; cfg_valid = 1'b0;
        repeat (4) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pll_cen_gen.md
PLL_CEN_GEN -- requirements
Module: pll_cen_gen

Interface
REQ-001 SHALL have parameter NUM_CLOCKS, default 2, number of enable channels (1..8).
REQ-002 SHALL have parameter ACC_W, default 32, phase-accumulator and step width.
REQ-003 SHALL have parameter LOCK_CYCLES, default 1024, settle count after lock (>=1).
REQ-004 SHALL have port refclk, input, 1, sole clock (PLL output domain).
REQ-005 SHALL have port rst, input, 1, reset; one clock, reset synchronous active-high.
REQ-006 SHALL have port locked, input, 1, PLL lock, asynchronous to refclk.
REQ-007 SHALL have port cfg_valid, input, 1, step-update request.
REQ-008 SHALL have port cfg_ready, output, 1, update accepted when cfg_valid&cfg_ready.
REQ-009 SHALL have port cfg_ch, input, max(1,$clog2(NUM_CLOCKS)), target channel.
REQ-010 SHALL have port cfg_step, input, ACC_W, new step; 0 = channel disabled.
REQ-011 SHALL have port sync, input, 1, realign all channel phases.
REQ-012 SHALL have port cen, output, NUM_CLOCKS, one-cycle enable pulses.
REQ-013 SHALL have port clk_div, output, NUM_CLOCKS, toggles on each cen pulse.
REQ-014 SHALL have port running, output, 1, high only in RUN.

Function
REQ-015 SHALL synchronise locked through two flops (locked_s) before use.
REQ-016 SHALL implement FSM WAIT_LOCK -> SETTLE (locked_s=1, counter cleared) -> RUN (counter reaches LOCK_CYCLES-1).
REQ-017 SHALL return to WAIT_LOCK on the edge after locked_s=0 in SETTLE or RUN.
REQ-018 SHALL, in RUN, add step[i] to acc[i] (ACC_W bits, wrap modulo 2^ACC_W) every cycle; cen[i] registered carry-out, one cycle after the overflowing add.
REQ-019 SHALL, outside RUN, hold acc, cen and clk_div at 0.
REQ-020 SHALL toggle clk_div[i] on the same edge cen[i] asserts.
REQ-021 SHALL hold cfg_ready=1 iff the channel addressed by cfg_ch has no pending update; cfg_ch>=NUM_CLOCKS: ready=1, write discarded.
REQ-022 SHALL store an accepted step as pending; apply it on that channel's next carry, or next edge if current step=0 or FSM not in RUN; clear pending on apply.
REQ-023 SHALL, on sync=1 in RUN, clear all acc and clk_div that edge; no cen that edge (sync overrides carry); pending updates still apply.
REQ-024 SHALL ignore sync outside RUN.
REQ-025 SHALL never assert cen on a channel whose step=0.

Reset
REQ-026 SHALL on rst: FSM=WAIT_LOCK, counter=0, acc=0, step=0, pending=0, cen=0, clk_div=0, running=0, cfg_ready=1, sync flops=0.
REQ-027 SHALL let rst override all other inputs, including mid-RUN and mid-handshake.

Structure
REQ-028 SHALL place FSM state enum and default ACC_W/LOCK_CYCLES constants in package pll_cen_pkg.
REQ-029 SHALL implement one channel (acc, step, pending, cen, clk_div) as sub-module pll_cen_chan, generated NUM_CLOCKS times; FSM and lock synchroniser in top.

Verification (bench: NUM_CLOCKS=2, ACC_W=8, LOCK_CYCLES=4)
REQ-030 SHALL cover: rst, then locked=1 -> running rises exactly 7 edges later; locked=0 in SETTLE -> running stays 0.
REQ-031 SHALL cover: ch0 step=64 in RUN -> cen[0] every 4 cycles, clk_div[0] period 8; ch1 step=0 -> cen[1] never.
REQ-032 SHALL cover: ch0 step=96 -> exactly 3 cen pulses per 8 cycles (acc 96,192,32c,128,224,64c,160,0c).
REQ-033 SHALL cover: ch0 at 64, write 128 mid-period -> cfg_ready=0 until next cen[0], then period 2; second write while pending stalls.
REQ-034 SHALL cover: locked drop in RUN -> running=0 within 3 edges, cen/clk_div/acc=0; relock repeats 7-edge settle.
REQ-035 SHALL cover: steps 64/32, sync=1 -> acc cleared, no cen that edge, next cen[0] 4 and cen[1] 8 cycles later.
